// File: rtl/binary_search_guesser.sv
// binary_search_guesser: drives an external magnitude comparator with
// successive midpoint guesses and binary-searches for its reference value,
// reporting the value found and how many probes it took.
module binary_search_guesser #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       Clk,
  input  logic                       nReset,
  input  logic                       Start,
  input  logic                       G,
  input  logic                       E,
  input  logic                       L,
  output logic [WIDTH-1:0]           Guess,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Error,
  output logic [WIDTH-1:0]           Found,
  output logic [$clog2(WIDTH+2)-1:0] GuessCount
);

  localparam int CW = $clog2(WIDTH + 2);

  // Last settle-counter value before the flags are trusted.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] low_q,   low_d;
  logic [WIDTH-1:0] high_q,  high_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] found_q, found_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       settle_q, settle_d;

  logic             flags_one_hot;

  // Midpoint of [a, b]; the sum is carried at WIDTH+1 bits so the top
  // of the range never overflows before the shift.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  assign flags_one_hot = ({G, E, L} == 3'b100) ||
                         ({G, E, L} == 3'b010) ||
                         ({G, E, L} == 3'b001);

  // Next-state and datapath updates for the search controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    low_d    = low_q;
    high_d   = high_q;
    guess_d  = guess_q;
    found_d  = found_q;
    count_d  = count_q;
    settle_d = settle_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          low_d    = '0;
          high_d   = '1;
          guess_d  = midpoint('0, '1);
          found_d  = '0;
          count_d  = '0;
          settle_d = '0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_EVAL;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_EVAL: begin
        count_d  = count_q + CW'(1);
        settle_d = '0;
        if (!flags_one_hot) begin
          state_d = S_ERROR;
        end else if (E) begin
          found_d = guess_q;
          state_d = S_DONE;
        end else if (G && (guess_q == high_q)) begin
          state_d = S_ERROR;
        end else if (L && (guess_q == low_q)) begin
          state_d = S_ERROR;
        end else if (G) begin
          low_d   = guess_q + WIDTH'(1);
          guess_d = midpoint(guess_q + WIDTH'(1), high_q);
          state_d = S_WAIT;
        end else begin
          high_d  = guess_q - WIDTH'(1);
          guess_d = midpoint(low_q, guess_q - WIDTH'(1));
          state_d = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by nReset.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      low_q    <= '0;
      high_q   <= '0;
      guess_q  <= '0;
      found_q  <= '0;
      count_q  <= '0;
      settle_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q  <= state_d;
      low_q    <= low_d;
      high_q   <= high_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      count_q  <= count_d;
      settle_q <= settle_d;
    end
  end

  assign Guess      = guess_q;
  assign Busy       = (state_q == S_WAIT) || (state_q == S_EVAL);
  assign Done       = (state_q == S_DONE);
  assign Error      = (state_q == S_ERROR);
  assign Found      = found_q;
  assign GuessCount = count_q;

endmodule
